// File: rtl/sect283r1_pt_mul_ctrl.sv
// sect283r1_pt_mul_ctrl
//
// Initiator-side sequencer for the sect283r1 point multiplier. It accepts
// one scalar at a time, rejects zero or out-of-range scalars (d >= n),
// launches the multiplier, waits for done (with a timeout), and returns the
// result with a status code.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous soft clear (drops any pending work)
//   req_valid/ready     scalar request handshake, req_d = scalar
//   rsp_valid/ready     response handshake, rsp_x/rsp_y/rsp_status
//                       (status 0=OK, 1=zero, 2=d>=n, 3=timeout)
//   busy                high whenever the sequencer is not idle
//   pm_clr/start/d      control to the point multiplier
//   pm_done/x/y         result from the point multiplier
module sect283r1_pt_mul_ctrl #(
  parameter logic [282:0] ORDER_N =
    283'h3FFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFEF90_399660FC_938A9016_5B042A7C_EFADB307,
  parameter logic [31:0]  TIMEOUT_CYC = 32'd1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [282:0] req_d,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [282:0] rsp_x,
  output logic [282:0] rsp_y,
  output logic [1:0]   rsp_status,
  output logic         busy,
  output logic         pm_clr,
  output logic         pm_start,
  output logic [282:0] pm_d,
  input  logic         pm_done,
  input  logic [282:0] pm_x,
  input  logic [282:0] pm_y
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] STAT_OK      = 2'd0;
  localparam logic [1:0] STAT_ZERO    = 2'd1;
  localparam logic [1:0] STAT_RANGE   = 2'd2;
  localparam logic [1:0] STAT_TIMEOUT = 2'd3;

  state_t         state_q, state_d;
  logic [282:0]   d_q, d_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [282:0]   rsp_x_q, rsp_x_d;
  logic [282:0]   rsp_y_q, rsp_y_d;
  logic [1:0]     rsp_status_q, rsp_status_d;
  logic           pm_clr_q, pm_clr_d;
  logic           pm_start_q, pm_start_d;
  logic [282:0]   pm_d_q, pm_d_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      d_q          <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_x_q      <= '0;
      rsp_y_q      <= '0;
      rsp_status_q <= STAT_OK;
      pm_clr_q     <= 1'b0;
      pm_start_q   <= 1'b0;
      pm_d_q       <= '0;
    end else begin
      state_q      <= state_d;
      d_q          <= d_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_x_q      <= rsp_x_d;
      rsp_y_q      <= rsp_y_d;
      rsp_status_q <= rsp_status_d;
      pm_clr_q     <= pm_clr_d;
      pm_start_q   <= pm_start_d;
      pm_d_q       <= pm_d_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    d_d          = d_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_x_d      = rsp_x_q;
    rsp_y_d      = rsp_y_q;
    rsp_status_d = rsp_status_q;
    pm_clr_d     = 1'b0;
    pm_start_d   = 1'b0;
    pm_d_d       = '0;

    if (clr) begin
      // Soft clear beats everything, including a handshake in the same cycle;
      // the multiplier is cleared too since it may be mid-operation.
      state_d      = ST_IDLE;
      d_d          = '0;
      cnt_d        = '0;
      rsp_valid_d  = 1'b0;
      rsp_x_d      = '0;
      rsp_y_d      = '0;
      rsp_status_d = STAT_OK;
      pm_clr_d     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            d_d     = req_d;
            state_d = ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (d_q == '0) begin
            rsp_status_d = STAT_ZERO;
            rsp_x_d      = '0;
            rsp_y_d      = '0;
            state_d      = ST_RESP;
          end else if (d_q >= ORDER_N) begin
            rsp_status_d = STAT_RANGE;
            rsp_x_d      = '0;
            rsp_y_d      = '0;
            state_d      = ST_RESP;
          end else begin
            state_d = ST_START;
          end
        end

        ST_START: begin
          // Start and d are registered, so they appear on the first WAIT
          // cycle; pm_d is forced back to zero on every other cycle.
          pm_start_d = 1'b1;
          pm_d_d     = d_q;
          cnt_d      = '0;
          state_d    = ST_WAIT;
        end

        ST_WAIT: begin
          cnt_d = cnt_q + 32'd1;
          // done is checked first so it wins over a coincident expiry.
          if (pm_done) begin
            rsp_x_d      = pm_x;
            rsp_y_d      = pm_y;
            rsp_status_d = STAT_OK;
            rsp_valid_d  = 1'b1;
            state_d      = ST_RESP;
          end else if (cnt_q == TIMEOUT_CYC - 32'd1) begin
            rsp_x_d      = '0;
            rsp_y_d      = '0;
            rsp_status_d = STAT_TIMEOUT;
            rsp_valid_d  = 1'b1;
            pm_clr_d     = 1'b1;
            state_d      = ST_RESP;
          end
        end

        ST_RESP: begin
          // Entered from CHECK with rsp_valid still low: it rises one cycle
          // later, and a handshake is only possible once it is high.
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            rsp_valid_d = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_x      = rsp_x_q;
  assign rsp_y      = rsp_y_q;
  assign rsp_status = rsp_status_q;
  assign pm_clr     = pm_clr_q;
  assign pm_start   = pm_start_q;
  assign pm_d       = pm_d_q;

endmodule
